// File: rtl/zueirai_mem.sv
// zueirai_mem: 1024x8 paged RAM with a boot loader that holds the core in
// reset while a byte stream fills memory. A 16-address memory-mapped I/O
// window on page 3 holds the port and interrupt configuration registers.
module zueirai_mem #(
  parameter int         BOOT_BYTES = 256,
  parameter logic [7:0] IO_BASE    = 8'hF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ctrl_MEM,
  input  logic [7:0]  out_MEM,
  output logic [7:0]  in_MEM,
  input  logic [7:0]  boot_data,
  input  logic        boot_valid,
  output logic        boot_ready,
  input  logic        boot_skip,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic [7:0]  DIR_A,
  output logic [7:0]  DIR_B,
  output logic [7:0]  DIR_C,
  output logic [7:0]  PORT_OUT_A,
  output logic [7:0]  PORT_OUT_B,
  output logic [7:0]  PORT_OUT_C,
  input  logic [7:0]  PORT_IN_A,
  input  logic [7:0]  PORT_IN_B,
  input  logic [7:0]  PORT_IN_C,
  output logic [7:0]  INT_CH,
  output logic [7:0]  INT_TYPE_0to3,
  output logic [7:0]  INT_TYPE_4to7
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [9:0] LAST_IDX = 10'(BOOT_BYTES - 1);

  state_t      state, state_next;
  logic [9:0]  cnt;
  logic [7:0]  mem [0:1023];

  logic [7:0]  addr;
  logic [1:0]  page;
  logic        load, write;
  logic [9:0]  idx;
  logic [8:0]  io_lo, io_hi;
  logic        is_io;
  logic [3:0]  io_off;
  logic [7:0]  io_rdata;

  logic        ram_we;
  logic [9:0]  ram_waddr;
  logic [7:0]  ram_wdata;

  logic [7:0]  sync1_a, sync1_b, sync1_c;
  logic [7:0]  sync2_a, sync2_b, sync2_c;

  assign addr  = ctrl_MEM[7:0];
  assign page  = ctrl_MEM[9:8];
  assign load  = ctrl_MEM[10];
  assign write = ctrl_MEM[11];
  assign idx   = {page, addr};

  // 9-bit bounds keep the window from wrapping; addr never exceeds 8'hFF,
  // so a base above 8'hF0 simply truncates the window at the top.
  assign io_lo  = {1'b0, IO_BASE};
  assign io_hi  = io_lo + 9'd15;
  assign is_io  = (page == 2'd3) && ({1'b0, addr} >= io_lo) && ({1'b0, addr} <= io_hi);
  assign io_off = addr[3:0] - IO_BASE[3:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // Next-state and boot handshake outputs
  always_comb begin
    state_next = state;
    boot_ready = 1'b0;
    cpu_hold   = 1'b0;
    boot_done  = 1'b0;
    case (state)
      BOOT: begin
        boot_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (boot_skip || (boot_valid && cnt == LAST_IDX)) state_next = RUN;
      end
      RUN: boot_done = 1'b1;
      default: state_next = BOOT;
    endcase
  end

  // RAM write port: boot stream during BOOT, core writes outside the window in RUN
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = idx;
    ram_wdata = out_MEM;
    if (!rst) begin
      if (state == BOOT) begin
        ram_we    = boot_valid;
        ram_waddr = cnt;
        ram_wdata = boot_data;
      end else begin
        ram_we = write && !is_io;
      end
    end
  end

  // RAM array, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Boot byte counter
  always_ff @(posedge clk) begin
    if (rst)                              cnt <= '0;
    else if (state == BOOT && boot_valid) cnt <= cnt + 10'd1;
  end

  // Two-flop synchronizers on the asynchronous port inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_a <= '0; sync1_b <= '0; sync1_c <= '0;
      sync2_a <= '0; sync2_b <= '0; sync2_c <= '0;
    end else begin
      sync1_a <= PORT_IN_A; sync1_b <= PORT_IN_B; sync1_c <= PORT_IN_C;
      sync2_a <= sync1_a;   sync2_b <= sync1_b;   sync2_c <= sync1_c;
    end
  end

  // MMIO configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      DIR_A <= '0; DIR_B <= '0; DIR_C <= '0;
      PORT_OUT_A <= '0; PORT_OUT_B <= '0; PORT_OUT_C <= '0;
      INT_CH <= '0; INT_TYPE_0to3 <= '0; INT_TYPE_4to7 <= '0;
    end else if (state == RUN && write && is_io) begin
      case (io_off)
        4'd0: DIR_A         <= out_MEM;
        4'd1: DIR_B         <= out_MEM;
        4'd2: DIR_C         <= out_MEM;
        4'd3: PORT_OUT_A    <= out_MEM;
        4'd4: PORT_OUT_B    <= out_MEM;
        4'd5: PORT_OUT_C    <= out_MEM;
        4'd6: INT_CH        <= out_MEM;
        4'd7: INT_TYPE_0to3 <= out_MEM;
        4'd8: INT_TYPE_4to7 <= out_MEM;
        default: ;
      endcase
    end
  end

  // MMIO read mux
  always_comb begin
    io_rdata = '0;
    case (io_off)
      4'd0:  io_rdata = DIR_A;
      4'd1:  io_rdata = DIR_B;
      4'd2:  io_rdata = DIR_C;
      4'd3:  io_rdata = PORT_OUT_A;
      4'd4:  io_rdata = PORT_OUT_B;
      4'd5:  io_rdata = PORT_OUT_C;
      4'd6:  io_rdata = INT_CH;
      4'd7:  io_rdata = INT_TYPE_0to3;
      4'd8:  io_rdata = INT_TYPE_4to7;
      4'd9:  io_rdata = sync2_a;
      4'd10: io_rdata = sync2_b;
      4'd11: io_rdata = sync2_c;
      default: io_rdata = '0;
    endcase
  end

  // Registered read data, write-first on simultaneous load and write
  always_ff @(posedge clk) begin
    if (rst || state == BOOT) begin
      in_MEM <= '0;
    end else if (load) begin
      if (write)      in_MEM <= out_MEM;
      else if (is_io) in_MEM <= io_rdata;
      else            in_MEM <= mem[idx];
    end
  end

endmodule
